// File: rtl/pulse_decoder.sv
// Registered N-to-2^N one-hot decoder with valid/ready accept.
// Each accepted code drives its one-hot line for PULSE_LEN cycles.
module pulse_decoder #(
    parameter int N         = 2,
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid,
    input  logic [N-1:0]         code,
    output logic                 ready,
    output logic [(1<<N)-1:0]    y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     count
);
    localparam int W  = 1 << N;
    // Holds PULSE_LEN-1; at least one bit so PULSE_LEN=1 still works.
    localparam int LW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [LW-1:0] LOAD = LW'(PULSE_LEN - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state, state_d;
    logic [LW-1:0]    left, left_d;
    logic [W-1:0]     y_d;
    logic             done_d;
    logic [CNT_W-1:0] count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            left  <= '0;
            y     <= '0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_d;
            left  <= left_d;
            y     <= y_d;
            done  <= done_d;
            count <= count_d;
        end
    end

    always_comb begin
        state_d = state;
        left_d  = left;
        y_d     = y;
        done_d  = 1'b0;
        count_d = count;
        unique case (state)
            IDLE: begin
                y_d = '0;
                if (valid && en) begin
                    y_d     = W'(1) << code;
                    left_d  = LOAD;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                unique case (1'b1)
                    !en: begin
                        y_d     = '0;
                        state_d = IDLE;
                    end
                    en && (left == '0): begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        count_d = count + 1'b1;
                        state_d = IDLE;
                    end
                    en && (left != '0): begin
                        left_d = left - 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == ACTIVE);

endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder: directed vector table, hand sequences,
// and randomized traffic against an edge-timeline reference model.
module tb_pulse_decoder;
    localparam int PL = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic       en_a, valid_a;
    logic [1:0] code_a;
    logic       ready_a, busy_a, done_a;
    logic [3:0] y_a;
    logic [7:0] count_a;

    logic       en_b, valid_b;
    logic [1:0] code_b;
    logic       ready_b, busy_b, done_b;
    logic [3:0] y_b;
    logic [1:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_decoder #(.N(2), .PULSE_LEN(PL), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .valid(valid_a),
        .code(code_a), .ready(ready_a), .y(y_a), .busy(busy_a),
        .done(done_a), .count(count_a)
    );

    pulse_decoder #(.N(2), .PULSE_LEN(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .valid(valid_b),
        .code(code_b), .ready(ready_b), .y(y_b), .busy(busy_b),
        .done(done_b), .count(count_b)
    );

    typedef struct {
        logic       en;
        logic       valid;
        logic [1:0] code;
        logic [3:0] y;
        logic       busy;
        logic       done;
        logic       ready;
        logic [7:0] count;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic v, input logic [1:0] c,
                       input logic [3:0] y, input logic b, input logic d,
                       input logic r, input logic [7:0] n);
        vec_t t;
        t.en = e; t.valid = v; t.code = c;
        t.y = y; t.busy = b; t.done = d; t.ready = r; t.count = n;
        tbl.push_back(t);
    endtask

    task automatic step_a(input logic e, input logic v, input logic [1:0] c);
        en_a = e; valid_a = v; code_a = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic e, input logic v, input logic [1:0] c);
        en_b = e; valid_b = v; code_b = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] y,
                           input logic b, input logic d, input logic r,
                           input logic [7:0] n);
        chk({tag, ".y"}, 32'(y_a), 32'(y));
        chk({tag, ".busy"}, 32'(busy_a), 32'(b));
        chk({tag, ".done"}, 32'(done_a), 32'(d));
        chk({tag, ".ready"}, 32'(ready_a), 32'(r));
        chk({tag, ".count"}, 32'(count_a), 32'(n));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step_a(tbl[i].en, tbl[i].valid, tbl[i].code);
            check_a($sformatf("row%0d", i), tbl[i].y, tbl[i].busy,
                    tbl[i].done, tbl[i].ready, tbl[i].count);
        end
    endtask

    initial begin
        int acc_edge, done_edge, e, m_count;
        logic [1:0] m_code;
        logic [3:0] exp_y;
        logic       re, rv;
        logic [1:0] rc;

        // single accept of code 2
        add(1, 1, 2, 4'b0100, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0100, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0100, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0100, 1, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, 1, 1, 1);
        add(1, 0, 0, 4'b0000, 0, 0, 1, 1);
        // back-to-back with valid held high
        add(1, 1, 0, 4'b0001, 1, 0, 0, 1);
        add(1, 1, 3, 4'b0001, 1, 0, 0, 1);
        add(1, 1, 3, 4'b0001, 1, 0, 0, 1);
        add(1, 1, 3, 4'b0001, 1, 0, 0, 1);
        add(1, 1, 3, 4'b0000, 0, 1, 1, 2);
        add(1, 1, 3, 4'b1000, 1, 0, 0, 2);
        add(1, 0, 0, 4'b1000, 1, 0, 0, 2);
        add(1, 0, 0, 4'b1000, 1, 0, 0, 2);
        add(1, 0, 0, 4'b1000, 1, 0, 0, 2);
        add(1, 0, 0, 4'b0000, 0, 1, 1, 3);
        // valid during ACTIVE is dropped
        add(1, 1, 1, 4'b0010, 1, 0, 0, 3);
        add(1, 1, 2, 4'b0010, 1, 0, 0, 3);
        add(1, 0, 0, 4'b0010, 1, 0, 0, 3);
        add(1, 0, 0, 4'b0010, 1, 0, 0, 3);
        add(1, 0, 0, 4'b0000, 0, 1, 1, 4);
        add(1, 0, 0, 4'b0000, 0, 0, 1, 4);
        // abort on second strobe cycle, then en=0 blocks accepts
        add(1, 1, 3, 4'b1000, 1, 0, 0, 4);
        add(1, 0, 0, 4'b1000, 1, 0, 0, 4);
        add(0, 0, 0, 4'b0000, 0, 0, 1, 4);
        add(0, 1, 2, 4'b0000, 0, 0, 1, 4);
        add(0, 1, 2, 4'b0000, 0, 0, 1, 4);
        add(1, 0, 0, 4'b0000, 0, 0, 1, 4);

        en_a = 0; valid_a = 0; code_a = 0;
        en_b = 0; valid_b = 0; code_b = 0;
        rst_n = 0;
        #12;
        check_a("reset", 4'b0000, 0, 0, 1, 0);
        rst_n = 1;

        run_rows(0, tbl.size() - 1);

        // asynchronous reset between edges, mid-strobe
        step_a(1, 1, 1);
        step_a(1, 0, 0);
        check_a("pre_rst", 4'b0010, 1, 0, 0, 4);
        #2 rst_n = 0;
        #1 check_a("async_rst", 4'b0000, 0, 0, 1, 0);
        #2 rst_n = 1;
        run_rows(0, 5);

        // randomized traffic against the timeline model
        #2 rst_n = 0;
        #2 rst_n = 1;
        acc_edge = -1; done_edge = -1; e = 0; m_count = 0; m_code = 0;
        for (int i = 0; i < 3000; i++) begin
            re = ($urandom_range(0, 9) != 0);
            rv = 1'($urandom_range(0, 1));
            rc = 2'($urandom_range(0, 3));
            step_a(re, rv, rc);
            e++;
            if (acc_edge >= 0) begin
                if (!re) begin
                    acc_edge = -1;
                end else if (e == acc_edge + PL) begin
                    m_count++;
                    done_edge = e;
                    acc_edge = -1;
                end
            end else if (re && rv) begin
                acc_edge = e;
                m_code = rc;
            end
            exp_y = (acc_edge >= 0) ? (4'b0001 << m_code) : 4'b0000;
            check_a("rand", exp_y, acc_edge >= 0, done_edge == e,
                    acc_edge < 0, 8'(m_count % 256));
            chk("onehot0", 32'($onehot0(y_a)), 32'd1);
            chk("busy_vs_y", 32'(busy_a), 32'(y_a != 0));
            chk("done_busy", 32'(done_a && busy_a), 32'd0);
        end

        // PULSE_LEN=1 and 2-bit counter wrap
        en_a = 0;
        for (int i = 0; i < 5; i++) begin
            step_b(1, 1, 1);
            chk("pl1.y", 32'(y_b), 32'h2);
            chk("pl1.busy", 32'(busy_b), 32'd1);
            chk("pl1.ready", 32'(ready_b), 32'd0);
            step_b(1, 0, 0);
            chk("pl1.y_off", 32'(y_b), 32'h0);
            chk("pl1.done", 32'(done_b), 32'd1);
            chk("pl1.ready_back", 32'(ready_b), 32'd1);
            chk("pl1.count", 32'(count_b), 32'((i + 1) % 4));
        end
        step_b(0, 0, 0);
        chk("pl1.done_clear", 32'(done_b), 32'd0);
        chk("wrap.count", 32'(count_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
